// File: rtl/array_multiplier_if.sv
// Operand/result bundle for the array multiplier.
// Master drives operands, slave returns the registered product.
interface array_multiplier_if #(
    parameter int WIDTH = 4
);
    logic                 in_valid;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [2*WIDTH-1:0]   product;
    logic                 out_valid;

    modport master (
        output in_valid, a, b,
        input  product, out_valid
    );

    modport slave (
        input  in_valid, a, b,
        output product, out_valid
    );
endinterface

// File: rtl/array_multiplier.sv
// Unsigned WIDTH x WIDTH array multiplier, one-cycle registered product.
// AND-gate partial products summed by shifted ripple-carry adder rows.
module array_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    array_multiplier_if.slave   bus
);

    logic [WIDTH-1:0]   pp [WIDTH];
    logic [2*WIDTH-1:0] prod_c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pp
        assign pp[i] = bus.a & {WIDTH{bus.b[i]}};
    end

    // Ripple each partial-product row into the running upper sum.
    always_comb begin
        logic [WIDTH-1:0] up;
        logic [WIDTH-1:0] s;
        logic [WIDTH:0]   cy;
        prod_c    = '0;
        s         = '0;
        cy        = '0;
        up        = {1'b0, pp[0][WIDTH-1:1]};
        prod_c[0] = pp[0][0];
        for (int i = 1; i < WIDTH; i++) begin
            cy[0] = 1'b0;
            for (int j = 0; j < WIDTH; j++) begin
                s[j]    = pp[i][j] ^ up[j] ^ cy[j];
                cy[j+1] = (pp[i][j] & up[j])
                        | (cy[j] & (pp[i][j] ^ up[j]));
            end
            prod_c[i] = s[0];
            up        = {cy[WIDTH], s[WIDTH-1:1]};
        end
        prod_c[2*WIDTH-1:WIDTH] = up;
    end

    // Capture the product on valid cycles; hold it otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.product   <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.product <= prod_c;
            end
        end
    end

endmodule

// File: tb/tb_array_multiplier.sv
// Self-checking bench for the 4x4 array multiplier.
// Directed table, hand sequences, exhaustive and random checks.
module tb_array_multiplier;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    array_multiplier_if #(.WIDTH(4)) bus ();

    array_multiplier #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } vec_t;

    vec_t       tbl [5];
    logic [7:0] res [16][16];
    logic [7:0] exp_p;
    logic       exp_v;

    task automatic check(input string name, input logic [15:0] got,
                         input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] x,
                         input logic [3:0] y);
        @(negedge clk);
        bus.in_valid = v;
        bus.a        = x;
        bus.b        = y;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        tbl[0] = '{4'b0000, 4'b0000, 8'd0};
        tbl[1] = '{4'b0001, 4'b0010, 8'd2};
        tbl[2] = '{4'b0011, 4'b0100, 8'd12};
        tbl[3] = '{4'b1111, 4'b1111, 8'd225};
        tbl[4] = '{4'b1010, 4'b0101, 8'd50};

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_product", 16'(bus.product), 16'd0);
        check("reset_valid", 16'(bus.out_valid), 16'd0);
        @(negedge clk);
        rst = 1'b0;

        // back-to-back directed table
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, tbl[k].a, tbl[k].b);
            check("tbl_product", 16'(bus.product), 16'(tbl[k].p));
            check("tbl_valid", 16'(bus.out_valid), 16'd1);
        end

        // idle cycle holds product, ignores operands
        drive(1'b0, 4'b1111, 4'b1111);
        check("hold_valid", 16'(bus.out_valid), 16'd0);
        check("hold_product", 16'(bus.product), 16'd50);

        // async reset mid-cycle with nonzero product
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_product", 16'(bus.product), 16'd0);
        check("async_rst_valid", 16'(bus.out_valid), 16'd0);
        @(negedge clk);
        rst = 1'b0;

        // exhaustive, continuous in_valid
        for (int k = 0; k < 256; k++) begin
            logic [3:0] x;
            logic [3:0] y;
            x = 4'(k >> 4);
            y = 4'(k);
            drive(1'b1, x, y);
            res[x][y] = bus.product;
            check("exh_product", 16'(bus.product), 16'(int'(x) * int'(y)));
            check("exh_valid", 16'(bus.out_valid), 16'd1);
        end
        for (int x = 0; x < 16; x++) begin
            for (int y = x + 1; y < 16; y++) begin
                check("commute", 16'(res[x][y]), 16'(res[y][x]));
            end
        end

        // random traffic against a last-valid model
        exp_p = res[15][15];
        exp_v = 1'b1;
        for (int k = 0; k < 300; k++) begin
            logic       v;
            logic [3:0] x;
            logic [3:0] y;
            v = 1'($urandom_range(0, 1));
            x = 4'($urandom);
            y = 4'($urandom);
            drive(v, x, y);
            if (v) exp_p = 8'(int'(x) * int'(y));
            exp_v = v;
            check("rnd_product", 16'(bus.product), 16'(exp_p));
            check("rnd_valid", 16'(bus.out_valid), 16'(exp_v));
        end

        // reset discards a multiply in flight
        drive(1'b1, 4'b0011, 4'b0011);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = 4'b0111;
        bus.b        = 4'b0110;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_product", 16'(bus.product), 16'd0);
        check("mid_rst_valid", 16'(bus.out_valid), 16'd0);
        @(posedge clk);
        #1;
        check("rst_hold_product", 16'(bus.product), 16'd0);
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        drive(1'b0, 4'b0111, 4'b0110);
        check("post_rst_product", 16'(bus.product), 16'd0);
        check("post_rst_valid", 16'(bus.out_valid), 16'd0);

        // first edge after release works normally
        drive(1'b1, 4'b1101, 4'b1011);
        check("release_product", 16'(bus.product), 16'd143);
        check("release_valid", 16'(bus.out_valid), 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
